// File: rtl/axi_mem_pkg.sv
// ---------------------------------------------------------------------------
// axi_mem_pkg
//   Shared definitions for the AXI memory window bridge: AXI response
//   encodings and the state types of the independent write and read FSMs.
// ---------------------------------------------------------------------------
package axi_mem_pkg;

  // AXI response encodings used by the bridge.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Beat counter width, wide enough for any AXI4 burst length (len + 1 <= 256).
  localparam int BEAT_CNT_WIDTH = 8;

  // Write-direction FSM states.
  typedef enum logic [2:0] {
    WR_IDLE,
    WR_PASS_AW,
    WR_PASS_DATA,
    WR_ERR_DATA,
    WR_ERR_RESP
  } wr_state_e;

  // Read-direction FSM states.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PASS_AR,
    RD_PASS_DATA,
    RD_ERR_DATA
  } rd_state_e;

endpackage

// File: rtl/axi_mem_window_err_rd.sv
// ---------------------------------------------------------------------------
// axi_mem_window_err_rd
//   Beat counter for DECERR read bursts. The parent read FSM owns rvalid;
//   this block only tracks which beat is being presented and flags the last.
//
// Ports
//   clk, rst  : clock and asynchronous active-high reset
//   start_i   : an out-of-window burst is being accepted; rewind to beat 0
//   beat_i    : an error beat is handshaking this cycle
//   len_i     : registered AXI len of the burst (beats - 1)
//   last_o    : the beat currently presented is the final one
// ---------------------------------------------------------------------------
module axi_mem_window_err_rd
  import axi_mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      beat_i,
  input  logic [BEAT_CNT_WIDTH-1:0] len_i,
  output logic                      last_o
);

  logic [BEAT_CNT_WIDTH-1:0] beat_q;
  logic [BEAT_CNT_WIDTH-1:0] beat_d;

  // Counter stops advancing on the final beat so it never wraps past len.
  always_comb begin
    beat_d = beat_q;
    if (start_i) begin
      beat_d = '0;
    end else if (beat_i && !last_o) begin
      beat_d = beat_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign last_o = (beat_q == len_i);

endmodule

// File: rtl/axi_mem_window.sv
// ---------------------------------------------------------------------------
// axi_mem_window
//   Bridges a core-side AXI4 slave port onto a RAM-side AXI4 master port.
//   Requests falling inside [BASE_ADDR, BASE_ADDR + 2^RAM_ADDR_WIDTH) are
//   forwarded with the base subtracted; anything else is answered locally
//   with DECERR. One transaction per direction is in flight at a time, and
//   reads and writes run independently.
//
// Ports
//   clk, rst        : clock and asynchronous active-high reset
//   s_axi_aw*/w*/b* : core-side write address, write data, write response
//   s_axi_ar*/r*    : core-side read address and read data
//   m_axi_*         : same five channels toward the RAM, RAM_ADDR_WIDTH addr
// ---------------------------------------------------------------------------
module axi_mem_window
  import axi_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 64,
  parameter int                    ADDR_WIDTH     = 34,
  parameter int                    RAM_ADDR_WIDTH = 16,
  parameter int                    ID_WIDTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 34'h0_8000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  // core AW
  input  logic [ID_WIDTH-1:0]       s_axi_awid_i,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr_i,
  input  logic [7:0]                s_axi_awlen_i,
  input  logic [2:0]                s_axi_awsize_i,
  input  logic [1:0]                s_axi_awburst_i,
  input  logic                      s_axi_awlock_i,
  input  logic [3:0]                s_axi_awcache_i,
  input  logic [2:0]                s_axi_awprot_i,
  input  logic                      s_axi_awvalid_i,
  output logic                      s_axi_awready_o,
  // core W
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb_i,
  input  logic                      s_axi_wlast_i,
  input  logic                      s_axi_wvalid_i,
  output logic                      s_axi_wready_o,
  // core B
  output logic [ID_WIDTH-1:0]       s_axi_bid_o,
  output logic [1:0]                s_axi_bresp_o,
  output logic                      s_axi_bvalid_o,
  input  logic                      s_axi_bready_i,
  // core AR
  input  logic [ID_WIDTH-1:0]       s_axi_arid_i,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr_i,
  input  logic [7:0]                s_axi_arlen_i,
  input  logic [2:0]                s_axi_arsize_i,
  input  logic [1:0]                s_axi_arburst_i,
  input  logic                      s_axi_arlock_i,
  input  logic [3:0]                s_axi_arcache_i,
  input  logic [2:0]                s_axi_arprot_i,
  input  logic                      s_axi_arvalid_i,
  output logic                      s_axi_arready_o,
  // core R
  output logic [ID_WIDTH-1:0]       s_axi_rid_o,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata_o,
  output logic [1:0]                s_axi_rresp_o,
  output logic                      s_axi_rlast_o,
  output logic                      s_axi_rvalid_o,
  input  logic                      s_axi_rready_i,
  // RAM AW
  output logic [ID_WIDTH-1:0]       m_axi_awid_o,
  output logic [RAM_ADDR_WIDTH-1:0] m_axi_awaddr_o,
  output logic [7:0]                m_axi_awlen_o,
  output logic [2:0]                m_axi_awsize_o,
  output logic [1:0]                m_axi_awburst_o,
  output logic                      m_axi_awlock_o,
  output logic [3:0]                m_axi_awcache_o,
  output logic [2:0]                m_axi_awprot_o,
  output logic                      m_axi_awvalid_o,
  input  logic                      m_axi_awready_i,
  // RAM W
  output logic [DATA_WIDTH-1:0]     m_axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb_o,
  output logic                      m_axi_wlast_o,
  output logic                      m_axi_wvalid_o,
  input  logic                      m_axi_wready_i,
  // RAM B
  input  logic [ID_WIDTH-1:0]       m_axi_bid_i,
  input  logic [1:0]                m_axi_bresp_i,
  input  logic                      m_axi_bvalid_i,
  output logic                      m_axi_bready_o,
  // RAM AR
  output logic [ID_WIDTH-1:0]       m_axi_arid_o,
  output logic [RAM_ADDR_WIDTH-1:0] m_axi_araddr_o,
  output logic [7:0]                m_axi_arlen_o,
  output logic [2:0]                m_axi_arsize_o,
  output logic [1:0]                m_axi_arburst_o,
  output logic                      m_axi_arlock_o,
  output logic [3:0]                m_axi_arcache_o,
  output logic [2:0]                m_axi_arprot_o,
  output logic                      m_axi_arvalid_o,
  input  logic                      m_axi_arready_i,
  // RAM R
  input  logic [ID_WIDTH-1:0]       m_axi_rid_i,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata_i,
  input  logic [1:0]                m_axi_rresp_i,
  input  logic                      m_axi_rlast_i,
  input  logic                      m_axi_rvalid_i,
  output logic                      m_axi_rready_o
);

  // Window decode: the offset from BASE_ADDR must be non-negative and fit in
  // RAM_ADDR_WIDTH bits. Testing the offset's upper bits avoids forming
  // BASE_ADDR + window size, which could overflow ADDR_WIDTH.
  logic [ADDR_WIDTH-1:0] aw_off;
  logic [ADDR_WIDTH-1:0] ar_off;
  logic                  aw_in_win;
  logic                  ar_in_win;

  assign aw_off    = s_axi_awaddr_i - BASE_ADDR;
  assign ar_off    = s_axi_araddr_i - BASE_ADDR;
  assign aw_in_win = (s_axi_awaddr_i >= BASE_ADDR) &&
                     (aw_off[ADDR_WIDTH-1:RAM_ADDR_WIDTH] == '0);
  assign ar_in_win = (s_axi_araddr_i >= BASE_ADDR) &&
                     (ar_off[ADDR_WIDTH-1:RAM_ADDR_WIDTH] == '0);

  // ---------------------------------------------------------------------
  // Write direction
  // ---------------------------------------------------------------------
  wr_state_e wr_state_q;
  wr_state_e wr_state_d;

  logic [ID_WIDTH-1:0]       aw_id_q;
  logic [RAM_ADDR_WIDTH-1:0] aw_addr_q;
  logic [7:0]                aw_len_q;
  logic [2:0]                aw_size_q;
  logic [1:0]                aw_burst_q;
  logic                      aw_lock_q;
  logic [3:0]                aw_cache_q;
  logic [2:0]                aw_prot_q;
  logic                      aw_accept;

  assign aw_accept = (wr_state_q == WR_IDLE) && s_axi_awvalid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE:      if (s_axi_awvalid_i) wr_state_d = aw_in_win ? WR_PASS_AW : WR_ERR_DATA;
      WR_PASS_AW:   if (m_axi_awready_i) wr_state_d = WR_PASS_DATA;
      WR_PASS_DATA: if (m_axi_bvalid_i && s_axi_bready_i) wr_state_d = WR_IDLE;
      WR_ERR_DATA:  if (s_axi_wvalid_i && s_axi_wlast_i) wr_state_d = WR_ERR_RESP;
      WR_ERR_RESP:  if (s_axi_bready_i) wr_state_d = WR_IDLE;
      default:      wr_state_d = WR_IDLE;
    endcase
  end

  // The id is captured for out-of-window requests too: the DECERR response
  // must echo it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      aw_lock_q  <= 1'b0;
      aw_cache_q <= '0;
      aw_prot_q  <= '0;
    end else if (aw_accept) begin
      aw_id_q    <= s_axi_awid_i;
      aw_addr_q  <= aw_off[RAM_ADDR_WIDTH-1:0];
      aw_len_q   <= s_axi_awlen_i;
      aw_size_q  <= s_axi_awsize_i;
      aw_burst_q <= s_axi_awburst_i;
      aw_lock_q  <= s_axi_awlock_i;
      aw_cache_q <= s_axi_awcache_i;
      aw_prot_q  <= s_axi_awprot_i;
    end
  end

  // W and B are straight wires in PASS_DATA; elsewhere the RAM side is held
  // idle and the core side is either blocked or served locally.
  always_comb begin
    s_axi_awready_o = 1'b0;
    m_axi_awvalid_o = 1'b0;
    s_axi_wready_o  = 1'b0;
    m_axi_wvalid_o  = 1'b0;
    s_axi_bvalid_o  = 1'b0;
    s_axi_bid_o     = aw_id_q;
    s_axi_bresp_o   = RESP_OKAY;
    m_axi_bready_o  = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        s_axi_awready_o = 1'b1;
      end
      WR_PASS_AW: begin
        m_axi_awvalid_o = 1'b1;
      end
      WR_PASS_DATA: begin
        m_axi_wvalid_o = s_axi_wvalid_i;
        s_axi_wready_o = m_axi_wready_i;
        s_axi_bvalid_o = m_axi_bvalid_i;
        s_axi_bid_o    = m_axi_bid_i;
        s_axi_bresp_o  = m_axi_bresp_i;
        m_axi_bready_o = s_axi_bready_i;
      end
      WR_ERR_DATA: begin
        s_axi_wready_o = 1'b1;
      end
      WR_ERR_RESP: begin
        s_axi_bvalid_o = 1'b1;
        s_axi_bresp_o  = RESP_DECERR;
      end
      default: begin
      end
    endcase
  end

  assign m_axi_awid_o    = aw_id_q;
  assign m_axi_awaddr_o  = aw_addr_q;
  assign m_axi_awlen_o   = aw_len_q;
  assign m_axi_awsize_o  = aw_size_q;
  assign m_axi_awburst_o = aw_burst_q;
  assign m_axi_awlock_o  = aw_lock_q;
  assign m_axi_awcache_o = aw_cache_q;
  assign m_axi_awprot_o  = aw_prot_q;
  assign m_axi_wdata_o   = s_axi_wdata_i;
  assign m_axi_wstrb_o   = s_axi_wstrb_i;
  assign m_axi_wlast_o   = s_axi_wlast_i;

  // ---------------------------------------------------------------------
  // Read direction
  // ---------------------------------------------------------------------
  rd_state_e rd_state_q;
  rd_state_e rd_state_d;

  logic [ID_WIDTH-1:0]       ar_id_q;
  logic [RAM_ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]                ar_len_q;
  logic [2:0]                ar_size_q;
  logic [1:0]                ar_burst_q;
  logic                      ar_lock_q;
  logic [3:0]                ar_cache_q;
  logic [2:0]                ar_prot_q;
  logic                      ar_accept;
  logic                      err_beat;
  logic                      err_last;

  assign ar_accept = (rd_state_q == RD_IDLE) && s_axi_arvalid_i;
  assign err_beat  = (rd_state_q == RD_ERR_DATA) && s_axi_rready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE:      if (s_axi_arvalid_i) rd_state_d = ar_in_win ? RD_PASS_AR : RD_ERR_DATA;
      RD_PASS_AR:   if (m_axi_arready_i) rd_state_d = RD_PASS_DATA;
      RD_PASS_DATA: if (m_axi_rvalid_i && s_axi_rready_i && m_axi_rlast_i) rd_state_d = RD_IDLE;
      RD_ERR_DATA:  if (err_beat && err_last) rd_state_d = RD_IDLE;
      default:      rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_lock_q  <= 1'b0;
      ar_cache_q <= '0;
      ar_prot_q  <= '0;
    end else if (ar_accept) begin
      ar_id_q    <= s_axi_arid_i;
      ar_addr_q  <= ar_off[RAM_ADDR_WIDTH-1:0];
      ar_len_q   <= s_axi_arlen_i;
      ar_size_q  <= s_axi_arsize_i;
      ar_burst_q <= s_axi_arburst_i;
      ar_lock_q  <= s_axi_arlock_i;
      ar_cache_q <= s_axi_arcache_i;
      ar_prot_q  <= s_axi_arprot_i;
    end
  end

  axi_mem_window_err_rd u_err_rd (
    .clk     (clk),
    .rst     (rst),
    .start_i (ar_accept),
    .beat_i  (err_beat),
    .len_i   (ar_len_q),
    .last_o  (err_last)
  );

  // R is a straight wire in PASS_DATA; in ERR_DATA zero-data DECERR beats
  // are generated locally with the registered id.
  always_comb begin
    s_axi_arready_o = 1'b0;
    m_axi_arvalid_o = 1'b0;
    s_axi_rvalid_o  = 1'b0;
    s_axi_rid_o     = ar_id_q;
    s_axi_rdata_o   = '0;
    s_axi_rresp_o   = RESP_OKAY;
    s_axi_rlast_o   = 1'b0;
    m_axi_rready_o  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        s_axi_arready_o = 1'b1;
      end
      RD_PASS_AR: begin
        m_axi_arvalid_o = 1'b1;
      end
      RD_PASS_DATA: begin
        s_axi_rvalid_o = m_axi_rvalid_i;
        s_axi_rid_o    = m_axi_rid_i;
        s_axi_rdata_o  = m_axi_rdata_i;
        s_axi_rresp_o  = m_axi_rresp_i;
        s_axi_rlast_o  = m_axi_rlast_i;
        m_axi_rready_o = s_axi_rready_i;
      end
      RD_ERR_DATA: begin
        s_axi_rvalid_o = 1'b1;
        s_axi_rresp_o  = RESP_DECERR;
        s_axi_rlast_o  = err_last;
      end
      default: begin
      end
    endcase
  end

  assign m_axi_arid_o    = ar_id_q;
  assign m_axi_araddr_o  = ar_addr_q;
  assign m_axi_arlen_o   = ar_len_q;
  assign m_axi_arsize_o  = ar_size_q;
  assign m_axi_arburst_o = ar_burst_q;
  assign m_axi_arlock_o  = ar_lock_q;
  assign m_axi_arcache_o = ar_cache_q;
  assign m_axi_arprot_o  = ar_prot_q;

endmodule

// File: tb/tb_axi_mem_window.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_window
//   Drives core-side AXI traffic into axi_mem_window, models the RAM behind
//   it, and checks every handshake against queued expectations.
// ---------------------------------------------------------------------------
module tb_axi_mem_window;
  import axi_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // core side
  logic [3:0]  s_awid, s_arid, s_bid, s_rid;
  logic [33:0] s_awaddr, s_araddr;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize, s_awprot, s_arprot;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic        s_awlock, s_arlock;
  logic [3:0]  s_awcache, s_arcache;
  logic        s_awvalid, s_awready, s_arvalid, s_arready;
  logic [63:0] s_wdata, s_rdata;
  logic [7:0]  s_wstrb;
  logic        s_wlast, s_wvalid, s_wready;
  logic        s_bvalid, s_bready, s_rlast, s_rvalid, s_rready;
  // RAM side
  logic [3:0]  m_awid, m_arid, m_bid, m_rid;
  logic [15:0] m_awaddr, m_araddr;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize, m_awprot, m_arprot;
  logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
  logic        m_awlock, m_arlock;
  logic [3:0]  m_awcache, m_arcache;
  logic        m_awvalid, m_awready, m_arvalid, m_arready;
  logic [63:0] m_wdata, m_rdata;
  logic [7:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready, m_rlast, m_rvalid, m_rready;

  axi_mem_window dut (
    .clk(clk), .rst(rst),
    .s_axi_awid_i(s_awid), .s_axi_awaddr_i(s_awaddr), .s_axi_awlen_i(s_awlen),
    .s_axi_awsize_i(s_awsize), .s_axi_awburst_i(s_awburst), .s_axi_awlock_i(s_awlock),
    .s_axi_awcache_i(s_awcache), .s_axi_awprot_i(s_awprot), .s_axi_awvalid_i(s_awvalid),
    .s_axi_awready_o(s_awready),
    .s_axi_wdata_i(s_wdata), .s_axi_wstrb_i(s_wstrb), .s_axi_wlast_i(s_wlast),
    .s_axi_wvalid_i(s_wvalid), .s_axi_wready_o(s_wready),
    .s_axi_bid_o(s_bid), .s_axi_bresp_o(s_bresp), .s_axi_bvalid_o(s_bvalid), .s_axi_bready_i(s_bready),
    .s_axi_arid_i(s_arid), .s_axi_araddr_i(s_araddr), .s_axi_arlen_i(s_arlen),
    .s_axi_arsize_i(s_arsize), .s_axi_arburst_i(s_arburst), .s_axi_arlock_i(s_arlock),
    .s_axi_arcache_i(s_arcache), .s_axi_arprot_i(s_arprot), .s_axi_arvalid_i(s_arvalid),
    .s_axi_arready_o(s_arready),
    .s_axi_rid_o(s_rid), .s_axi_rdata_o(s_rdata), .s_axi_rresp_o(s_rresp), .s_axi_rlast_o(s_rlast),
    .s_axi_rvalid_o(s_rvalid), .s_axi_rready_i(s_rready),
    .m_axi_awid_o(m_awid), .m_axi_awaddr_o(m_awaddr), .m_axi_awlen_o(m_awlen),
    .m_axi_awsize_o(m_awsize), .m_axi_awburst_o(m_awburst), .m_axi_awlock_o(m_awlock),
    .m_axi_awcache_o(m_awcache), .m_axi_awprot_o(m_awprot), .m_axi_awvalid_o(m_awvalid),
    .m_axi_awready_i(m_awready),
    .m_axi_wdata_o(m_wdata), .m_axi_wstrb_o(m_wstrb), .m_axi_wlast_o(m_wlast),
    .m_axi_wvalid_o(m_wvalid), .m_axi_wready_i(m_wready),
    .m_axi_bid_i(m_bid), .m_axi_bresp_i(m_bresp), .m_axi_bvalid_i(m_bvalid), .m_axi_bready_o(m_bready),
    .m_axi_arid_o(m_arid), .m_axi_araddr_o(m_araddr), .m_axi_arlen_o(m_arlen),
    .m_axi_arsize_o(m_arsize), .m_axi_arburst_o(m_arburst), .m_axi_arlock_o(m_arlock),
    .m_axi_arcache_o(m_arcache), .m_axi_arprot_o(m_arprot), .m_axi_arvalid_o(m_arvalid),
    .m_axi_arready_i(m_arready),
    .m_axi_rid_i(m_rid), .m_axi_rdata_i(m_rdata), .m_axi_rresp_i(m_rresp), .m_axi_rlast_i(m_rlast),
    .m_axi_rvalid_i(m_rvalid), .m_axi_rready_o(m_rready)
  );

  // RAM model: one burst per direction, INCR bursts of 8-byte beats.
  logic [63:0] ram [0:8191];
  logic        ramWBusy, ramBPend, ramRBusy;
  logic [12:0] ramWPtr, ramRPtr;
  logic [7:0]  ramRCnt, ramRLen;
  logic [3:0]  ramWId, ramRId;

  assign m_awready = !ramWBusy;
  assign m_wready  = ramWBusy && !ramBPend;
  assign m_bvalid  = ramBPend;
  assign m_bid     = ramWId;
  assign m_bresp   = RESP_OKAY;
  assign m_arready = !ramRBusy;
  assign m_rvalid  = ramRBusy;
  assign m_rid     = ramRId;
  assign m_rdata   = ram[ramRPtr];
  assign m_rresp   = RESP_OKAY;
  assign m_rlast   = (ramRCnt == ramRLen);

  always @(posedge clk) begin
    if (!rst && m_wvalid && m_wready) ram[ramWPtr] <= m_wdata;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ramWBusy <= 1'b0; ramBPend <= 1'b0; ramRBusy <= 1'b0;
      ramWPtr <= '0; ramRPtr <= '0; ramRCnt <= '0; ramRLen <= '0;
      ramWId <= '0; ramRId <= '0;
    end else begin
      if (m_awvalid && m_awready) begin
        ramWBusy <= 1'b1; ramWPtr <= m_awaddr[15:3]; ramWId <= m_awid;
      end
      if (m_wvalid && m_wready) begin
        ramWPtr <= ramWPtr + 13'd1;
        if (m_wlast) ramBPend <= 1'b1;
      end
      if (m_bvalid && m_bready) begin
        ramBPend <= 1'b0; ramWBusy <= 1'b0;
      end
      if (m_arvalid && m_arready) begin
        ramRBusy <= 1'b1; ramRPtr <= m_araddr[15:3]; ramRLen <= m_arlen;
        ramRCnt <= '0; ramRId <= m_arid;
      end
      if (m_rvalid && m_rready) begin
        if (m_rlast) ramRBusy <= 1'b0;
        else begin
          ramRCnt <= ramRCnt + 8'd1; ramRPtr <= ramRPtr + 13'd1;
        end
      end
    end
  end

  // Scoreboard queues.
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } bExp_t;
  typedef struct packed { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rExp_t;
  typedef struct packed { logic [15:0] addr; logic [7:0] len; logic [3:0] id; } axExp_t;
  typedef struct packed { logic [63:0] data; logic last; } wExp_t;

  bExp_t  expB[$];
  rExp_t  expR[$];
  axExp_t expMaw[$];
  axExp_t expMar[$];
  wExp_t  expMw[$];

  int checkCount = 0;
  int passCount  = 0;
  int rBeats     = 0;
  int awValidCnt = 0;
  int arValidCnt = 0;
  bit randReady  = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic failTimeout(input string name);
    checkCount++;
    $display("[TB] FAIL %s: got timeout expected completion", name);
  endtask

  // Monitor: pops an expectation on each handshake seen from mid-cycle.
  bExp_t eB; rExp_t eR; axExp_t eA; wExp_t eW;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_awvalid) awValidCnt++;
      if (m_arvalid) arValidCnt++;
      if (s_bvalid && s_bready) begin
        if (expB.size() == 0) failTimeout("unexpected_b");
        else begin
          eB = expB.pop_front();
          checkOutput("b_id_resp", {s_bid, s_bresp}, eB);
        end
      end
      if (s_rvalid && s_rready) begin
        rBeats++;
        if (expR.size() == 0) failTimeout("unexpected_r");
        else begin
          eR = expR.pop_front();
          checkOutput("r_beat", {s_rid, s_rdata, s_rresp, s_rlast}, eR);
        end
      end
      if (m_awvalid && m_awready) begin
        if (expMaw.size() == 0) failTimeout("unexpected_m_aw");
        else begin
          eA = expMaw.pop_front();
          checkOutput("m_aw_fields",
                      {m_awaddr, m_awlen, m_awid, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot},
                      {eA, 3'd3, 2'd1, 1'b0, 4'h3, 3'h2});
        end
      end
      if (m_arvalid && m_arready) begin
        if (expMar.size() == 0) failTimeout("unexpected_m_ar");
        else begin
          eA = expMar.pop_front();
          checkOutput("m_ar_fields",
                      {m_araddr, m_arlen, m_arid, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot},
                      {eA, 3'd3, 2'd1, 1'b0, 4'h3, 3'h2});
        end
      end
      if (m_wvalid && m_wready) begin
        if (expMw.size() == 0) failTimeout("unexpected_m_w");
        else begin
          eW = expMw.pop_front();
          checkOutput("m_w_beat", {m_wdata, m_wlast}, eW);
        end
      end
    end
  end

  // Response-side ready generator: optionally random back-pressure.
  initial begin
    s_bready = 1'b1;
    s_rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      s_bready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      s_rready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic doWrite(input logic [3:0] id, input logic [33:0] addr, input logic [7:0] len,
                         input logic [63:0] base, input bit ok, input logic [15:0] mAddr);
    int n;
    expB.push_back({id, ok ? RESP_OKAY : RESP_DECERR});
    if (ok) begin
      expMaw.push_back({mAddr, len, id});
      for (int i = 0; i <= int'(len); i++) expMw.push_back({base + 64'(i), i == int'(len)});
    end
    @(posedge clk); #1;
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_awready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin failTimeout("aw_accept"); s_awvalid = 1'b0; return; end
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    @(negedge clk);
    checkOutput("aw_to_m_awvalid", m_awvalid, ok ? 1 : 0);
    @(posedge clk); #1;
    for (int i = 0; i <= int'(len); i++) begin
      s_wvalid = 1'b1; s_wdata = base + 64'(i); s_wlast = (i == int'(len));
      n = 0;
      @(negedge clk);
      while (!s_wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin failTimeout("w_accept"); break; end
      @(posedge clk); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    if (!ok) begin
      @(negedge clk);
      checkOutput("decerr_bvalid_latency", s_bvalid, 1);
    end
    n = 0;
    while (expB.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) failTimeout("b_complete");
  endtask

  task automatic doRead(input logic [3:0] id, input logic [33:0] addr, input logic [7:0] len,
                        input logic [63:0] base, input bit ok, input logic [15:0] mAddr,
                        input bit waitDone);
    int n;
    if (ok) expMar.push_back({mAddr, len, id});
    for (int i = 0; i <= int'(len); i++)
      expR.push_back({id, ok ? base + 64'(i) : 64'd0, ok ? RESP_OKAY : RESP_DECERR, i == int'(len)});
    @(posedge clk); #1;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin failTimeout("ar_accept"); s_arvalid = 1'b0; return; end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);
    if (ok) checkOutput("ar_to_m_arvalid", m_arvalid, 1);
    else    checkOutput("decerr_rvalid_latency", s_rvalid, 1);
    if (waitDone) begin
      n = 0;
      while (expR.size() != 0 && n < 400) begin @(negedge clk); n++; end
      if (n >= 400) failTimeout("r_complete");
    end
  endtask

  task automatic applyStimulus(input bit isWrite, input logic [3:0] id, input logic [33:0] addr,
                               input logic [7:0] len, input logic [63:0] base, input bit ok,
                               input logic [15:0] mAddr);
    if (isWrite) doWrite(id, addr, len, base, ok, mAddr);
    else         doRead(id, addr, len, base, ok, mAddr, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int snap;
    int n;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd3; s_awburst = 2'd1;
    s_awlock = 1'b0; s_awcache = 4'h3; s_awprot = 3'h2; s_awvalid = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd3; s_arburst = 2'd1;
    s_arlock = 1'b0; s_arcache = 4'h3; s_arprot = 3'h2; s_arvalid = 1'b0;
    s_wdata = '0; s_wstrb = 8'hFF; s_wlast = 1'b0; s_wvalid = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valids", {s_bvalid, s_rvalid, m_awvalid, m_arvalid, m_wvalid}, 5'b0);
    checkOutput("reset_m_readies", {m_bready, m_rready}, 2'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {s_awready, s_arready}, 2'b11);

    // W presented before AW must be back-pressured.
    @(posedge clk); #1;
    s_wvalid = 1'b1; s_wdata = 64'hDEAD; s_wlast = 1'b0;
    @(negedge clk);
    checkOutput("w_before_aw_blocked", s_wready, 0);
    s_wvalid = 1'b0;

    // In-window write, then read it back.
    applyStimulus(1'b1, 4'd2, 34'h0_8000_0100, 8'd3, 64'hA000_0000_0000_0000, 1'b1, 16'h0100);
    applyStimulus(1'b0, 4'd3, 34'h0_8000_0100, 8'd3, 64'hA000_0000_0000_0000, 1'b1, 16'h0100);

    // Out-of-window read: eight DECERR beats, RAM untouched.
    snap = arValidCnt;
    applyStimulus(1'b0, 4'd5, 34'h0_0000_1000, 8'd7, 64'd0, 1'b0, 16'h0);
    checkOutput("decerr_rd_no_m_arvalid", 32'(arValidCnt - snap), 0);

    // First address past the window: write absorbed with DECERR.
    snap = awValidCnt;
    applyStimulus(1'b1, 4'd6, 34'h0_8001_0000, 8'd1, 64'hD000, 1'b0, 16'h0);
    checkOutput("decerr_wr_no_m_awvalid", 32'(awValidCnt - snap), 0);

    // Concurrent write and read with random response back-pressure.
    randReady = 1'b1;
    fork
      doWrite(4'd7, 34'h0_8000_0200, 8'd3, 64'hC000_0000_0000_0000, 1'b1, 16'h0200);
      doRead(4'd8, 34'h0_8000_0100, 8'd3, 64'hA000_0000_0000_0000, 1'b1, 16'h0100, 1'b1);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("aw_ar_same_cycle", {s_awvalid && s_awready, s_arvalid && s_arready}, 2'b11);
      end
    join
    applyStimulus(1'b0, 4'd1, 34'h0_8000_0200, 8'd3, 64'hC000_0000_0000_0000, 1'b1, 16'h0200);
    randReady = 1'b0;

    // Reset in the middle of a DECERR read, at beat 3 of 8.
    snap = rBeats;
    doRead(4'd9, 34'h0_0000_2000, 8'd7, 64'd0, 1'b0, 16'h0, 1'b0);
    n = 0;
    do begin @(posedge clk); n++; end while ((rBeats - snap) < 3 && n < 100);
    if (n >= 100) failTimeout("reach_beat3");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rvalid_drops_on_reset", s_rvalid, 0);
    expR.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_mid_reset", {s_awready, s_arready, s_rvalid}, 3'b110);
    applyStimulus(1'b0, 4'd10, 34'h0_8000_0100, 8'd3, 64'hA000_0000_0000_0000, 1'b1, 16'h0100);

    repeat (3) @(negedge clk);
    checkOutput("queues_drained", {32'(expB.size()), 32'(expR.size()), 32'(expMaw.size()),
                                   32'(expMar.size())}, 128'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/axi_mem_window.md
AXI_MEM_WINDOW -- requirements
Module: axi_mem_window

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, AXI data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 34, core-side address width.
REQ-003 SHALL have parameter RAM_ADDR_WIDTH, default 16, RAM-side address width (window = 2^RAM_ADDR_WIDTH bytes).
REQ-004 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-005 SHALL have parameter BASE_ADDR, default 34'h0_8000_0000, window base, aligned to 2^RAM_ADDR_WIDTH.
REQ-006 SHALL have one clock and an asynchronous, active-high reset.
REQ-007 SHALL have port clk, input, 1, sole clock.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port group s_axi_aw*, input bundle (ready output), AXI4 AW from core: id, addr[ADDR_WIDTH], len[8], size[3], burst[2], lock, cache[4], prot[3], valid/ready.
REQ-010 SHALL have port group s_axi_w* and s_axi_b*, AXI4 W (data, strb, last) and B (id, resp) with core.
REQ-011 SHALL have port group s_axi_ar* and s_axi_r*, AXI4 AR and R (id, data, resp, last) with core.
REQ-012 SHALL have port group m_axi_*, mirror of all five channels toward RAM, with addr width RAM_ADDR_WIDTH and no qos.

Function
REQ-013 SHALL classify a request as in-window iff BASE_ADDR <= addr < BASE_ADDR + 2^RAM_ADDR_WIDTH.
REQ-014 SHALL forward in-window requests with m addr = (addr - BASE_ADDR)[RAM_ADDR_WIDTH-1:0]; id, len, size, burst, lock, cache and prot are unchanged.
REQ-015 SHALL run independent write FSM states IDLE, PASS_AW, PASS_DATA, ERR_DATA, ERR_RESP.
REQ-016 Write FSM IDLE: s_axi_awready=1; on AW handshake, register the request and go to PASS_AW (in-window) or ERR_DATA (out-of-window).
REQ-017 Write FSM PASS_AW: m_axi_awvalid=1 from register; on m handshake go to PASS_DATA.
REQ-018 Write FSM PASS_DATA: route W core->RAM and B RAM->core combinationally; on B handshake go to IDLE.
REQ-019 Write FSM ERR_DATA: s_axi_wready=1, discard beats; on the beat with wlast go to ERR_RESP.
REQ-020 Write FSM ERR_RESP: s_axi_bvalid=1, bresp=2'b11 (DECERR), bid = registered id; on bready go to IDLE.
REQ-021 SHALL run a read FSM with states IDLE, PASS_AR, PASS_DATA, ERR_DATA, mirroring the write FSM.
REQ-022 Read FSM ERR_DATA: emit exactly len+1 beats with rdata=0, rresp=2'b11, rid = registered id, rlast only on the final beat, using an 8-bit beat counter.
REQ-023 Read FSM PASS_DATA: return to IDLE on R handshake with rlast=1.
REQ-024 SHALL allow at most one outstanding transaction per direction; awready/arready SHALL be 0 outside IDLE.
REQ-025 SHALL hold every valid stable until its handshake, and SHALL NOT let valid depend on ready.
REQ-026 SHALL process reads and writes concurrently; simultaneous AW and AR in the same cycle SHALL both be accepted.
REQ-027 SHALL make latency AW/AR accept -> m valid exactly 1 cycle; DECERR B/first R exactly 1 cycle after wlast/AR accept.
REQ-028 SHALL drive m W/B/R handshakes inactive (valid=0, ready=0) outside PASS_DATA.
REQ-029 SHALL accept a W beat in IDLE only after AW handshake; W before AW SHALL be back-pressured (wready=0).

Reset
REQ-030 On rst, both FSMs SHALL go to IDLE, counters and registers SHALL clear, and all valid outputs SHALL be 0; awready/arready SHALL become 1 on the first cycle after deassertion.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no response; RAM SHALL share the same rst.

Structure
REQ-032 SHALL place resp encodings (OKAY=2'b00, DECERR=2'b11) and FSM state typedefs in shared package axi_mem_pkg.
REQ-033 SHALL implement read and write FSMs in one file; sub-module axi_mem_window_err_rd (DECERR beat generator) is optional.

Verification
REQ-034 Write to 0x0_8000_0100, len=3, 4 beats -> m awaddr=0x0100, m awlen=3, 4 beats forwarded, B OKAY with matching id.
REQ-035 Read from 0x0_8000_0100, len=3 after the write -> 4 beats equal the written data, rlast on beat 4, rresp OKAY.
REQ-036 Read from 0x0_0000_1000, len=7, id=5 -> 8 beats, rdata 0, rresp 2'b11, rid 5, rlast on beat 8 only, m_axi_arvalid never 1.
REQ-037 Write to 0x0_8001_0000 (first address past window), len=1 -> 2 beats absorbed, B DECERR, m_axi_awvalid never 1.
REQ-038 AW and AR in the same cycle, both in-window, with bready/rready randomly deasserted -> both complete with correct data and no lost beats.
REQ-039 rst asserted during a DECERR read at beat 3 of 8 -> rvalid=0 at once; the next read after reset completes normally.
